// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared state enum, output constants and hex-to-7-segment table for the scan driver
package seg_scan_pkg;
  typedef enum logic [1:0] {BLANK, DRIVE, FAULT} scan_state_t;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF = 4'hF;
  localparam logic [3:0] FRAME_SEL = 4'b1000;
  // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element
  localparam logic [15:0][6:0] HEX7 = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic logic is_onehot(input logic [3:0] s);
    return (s != 4'b0000) && ((s & (s - 4'd1)) == 4'b0000);
  endfunction
  function automatic logic [1:0] sel_idx(input logic [3:0] s);
    return s[3] ? 2'd3 : s[2] ? 2'd2 : s[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: 4-bit nibble to active-low 7-segment pattern
module seg_hex_decoder
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);
  assign pattern = HEX7[nibble];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed 7-segment driver with blanking, frame-synchronised commit and fault flag; SEG_DP_EN adds decimal points
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sel,
  input  logic [15:0] data_in,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        err
`ifdef SEG_DP_EN
  ,
  input  logic [3:0]  dp_in,
  output logic        dp
`endif
);
  localparam int CNT_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
`ifdef SEG_DP_EN
  localparam int SH_W = 20;
  logic [SH_W-1:0] data_w;
  assign data_w = {dp_in, data_in};
`else
  localparam int SH_W = 16;
  logic [SH_W-1:0] data_w;
  assign data_w = data_in;
`endif
  scan_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [3:0] sel_q;
  logic [SH_W-1:0] shadow, pend_data;
  logic pend, chg, frame, drive;
  logic [1:0] idx;
  logic [6:0] pattern;
  assign chg = sel != sel_q;
  assign frame = chg && (sel == FRAME_SEL);
  assign drive = state == DRIVE;
  assign idx = sel_idx(sel_q);
  // Blank/drive/fault sequencing; err latches on any entry into FAULT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      cnt <= '0;
      err <= 1'b0;
    end else if (chg && BLANK_CYC > 0) begin
      state <= BLANK;
      cnt <= CNT_INIT;
    end else if (chg) begin
      state <= is_onehot(sel) ? DRIVE : FAULT;
      err <= err | ~is_onehot(sel);
    end else if (state == BLANK && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end else if (state == BLANK) begin
      state <= is_onehot(sel_q) ? DRIVE : FAULT;
      err <= err | ~is_onehot(sel_q);
    end
  end
  // Track the select and commit new data only at frame start so a frame never tears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= 4'b0000;
      shadow <= '0;
      pend_data <= '0;
      pend <= 1'b0;
    end else begin
      sel_q <= sel;
      if (load) pend_data <= data_w;
      if (load && frame) begin
        shadow <= data_w;
        pend <= 1'b0;
      end else if (load) begin
        pend <= 1'b1;
      end else if (frame && pend) begin
        shadow <= pend_data;
        pend <= 1'b0;
      end
    end
  end
  seg_hex_decoder u_dec (
    .nibble (shadow[{idx, 2'b00} +: 4]),
    .pattern(pattern)
  );
  // Outputs depend only on registered state
  always_comb begin
    an = drive ? ~sel_q : AN_OFF;
    seg = drive ? pattern : SEG_OFF;
  end
`ifdef SEG_DP_EN
  logic [3:0] dp_sh;
  assign dp_sh = shadow[19:16];
  assign dp = drive ? ~dp_sh[idx] : 1'b1;
`endif
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed table-driven bench for seg_scan_driver (BLANK_CYC=2)
module tb_seg_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] sel = 4'b1000;
  logic [15:0] data_in = 16'h0000;
  logic load = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic err;
`ifdef SEG_DP_EN
  logic [3:0] dp_in = 4'b0000;
  logic dp;
`endif
  int checks = 0;
  int errors = 0;

  seg_scan_driver #(.BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .sel(sel), .data_in(data_in), .load(load),
    .an(an), .seg(seg), .err(err)
`ifdef SEG_DP_EN
    , .dp_in(dp_in), .dp(dp)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] data;
    logic        load;
    int          n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        err;
  } vec_t;
  vec_t vec [10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_err);
    check({tag, ".an"}, {12'h0, an}, {12'h0, e_an});
    check({tag, ".seg"}, {9'h0, seg}, {9'h0, e_seg});
    check({tag, ".err"}, {15'h0, err}, {15'h0, e_err});
`ifdef SEG_DP_EN
    check({tag, ".dp"}, {15'h0, dp}, 16'h0001);
`endif
  endtask

  task automatic step(input string tag, input logic [3:0] s, input logic [15:0] d, input logic l,
                      input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_err);
    sel = s;
    data_in = d;
    load = l;
    @(posedge clk);
    @(negedge clk);
    check_out(tag, e_an, e_seg, e_err);
  endtask

  initial begin
    logic [3:0] rapid [6];
    vec[0] = '{4'b1000, 16'h1234, 1'b1, 8, 4'b0111, 7'h79, 1'b0};
    vec[1] = '{4'b0100, 16'hABCD, 1'b1, 8, 4'b1011, 7'h24, 1'b0};
    vec[2] = '{4'b0010, 16'hABCD, 1'b0, 8, 4'b1101, 7'h30, 1'b0};
    vec[3] = '{4'b0001, 16'hABCD, 1'b0, 8, 4'b1110, 7'h19, 1'b0};
    vec[4] = '{4'b1000, 16'hABCD, 1'b0, 8, 4'b0111, 7'h08, 1'b0};
    vec[5] = '{4'b0100, 16'hABCD, 1'b0, 4, 4'b1011, 7'h03, 1'b0};
    vec[6] = '{4'b0010, 16'h5678, 1'b1, 4, 4'b1101, 7'h46, 1'b0};
    vec[7] = '{4'b0001, 16'h9E00, 1'b1, 4, 4'b1110, 7'h21, 1'b0};
    vec[8] = '{4'b1000, 16'h9E00, 1'b0, 4, 4'b0111, 7'h10, 1'b0};
    vec[9] = '{4'b0100, 16'h9E00, 1'b0, 4, 4'b1011, 7'h06, 1'b0};
    rapid = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
    #2;
    check_out("reset", 4'hF, 7'h7F, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < vec[r].n; c++)
        step($sformatf("vec%0d.c%0d", r, c), vec[r].sel, vec[r].data, vec[r].load && c == 0,
             c < 2 ? 4'hF : vec[r].an, c < 2 ? 7'h7F : vec[r].seg, vec[r].err);
    for (int c = 0; c < 5; c++)
      step($sformatf("fault.c%0d", c), 4'b0110, 16'h9E00, 1'b0, 4'hF, 7'h7F, c >= 2);
    for (int c = 0; c < 4; c++)
      step($sformatf("recover.c%0d", c), 4'b0010, 16'h9E00, 1'b0,
           c < 2 ? 4'hF : 4'b1101, c < 2 ? 7'h7F : 7'h40, 1'b1);
    for (int c = 0; c < 6; c++)
      step($sformatf("rapid.c%0d", c), rapid[c], 16'h9E00, 1'b0, 4'hF, 7'h7F, 1'b1);
    for (int c = 0; c < 3; c++)
      step($sformatf("settle.c%0d", c), 4'b0100, 16'h9E00, 1'b0,
           c < 1 ? 4'hF : 4'b1011, c < 1 ? 7'h7F : 7'h06, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_out("async_rst", 4'hF, 7'h7F, 1'b0);
    @(negedge clk);
    sel = 4'b0010;
    rst = 1'b0;
    for (int c = 0; c < 3; c++)
      step($sformatf("post_rst.c%0d", c), 4'b0010, 16'h9E00, 1'b0,
           c < 2 ? 4'hF : 4'b1101, c < 2 ? 7'h7F : 7'h40, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
